// File: rtl/smoldvi_stream_frontend.sv
`timescale 1ns/1ps
// SmolDVI pixel-clock front end: buffered {sof,rgb} pixel stream feeding a built-in
// video timing generator with pixel repetition, frame resync and underrun recovery.
module smoldvi_stream_frontend #(
    parameter logic        H_SYNC_POLARITY         = 1'b0,
    parameter int unsigned H_FRONT_PORCH           = 16,
    parameter int unsigned H_SYNC_WIDTH            = 96,
    parameter int unsigned H_BACK_PORCH            = 48,
    parameter int unsigned H_ACTIVE_PIXELS         = 640,
    parameter logic        V_SYNC_POLARITY         = 1'b0,
    parameter int unsigned V_FRONT_PORCH           = 10,
    parameter int unsigned V_SYNC_WIDTH            = 2,
    parameter int unsigned V_BACK_PORCH            = 33,
    parameter int unsigned V_ACTIVE_LINES          = 480,
    parameter int unsigned PIX_REPEAT              = 1,
    parameter int unsigned FIFO_DEPTH              = 16,
    parameter int unsigned COLOUR_SIGNIFICANT_BITS = 6,
    parameter logic [23:0] BORDER_RGB              = 24'h000000
) (
    input  logic                          clk_pix,
    input  logic                          rst_n_pix,
    input  logic                          en,
    input  logic [23:0]                   pix_data,
    input  logic                          pix_sof,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic                          den,
    output logic                          hsync,
    output logic                          vsync,
    output logic [7:0]                    r,
    output logic [7:0]                    g,
    output logic [7:0]                    b,
    output logic                          frame_start,
    output logic                          err_underrun,
    output logic                          err_sof,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned H_TOTAL = H_ACTIVE_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int unsigned V_TOTAL = V_ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);
    localparam int unsigned RW = $clog2(PIX_REPEAT + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE_PIXELS);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE_PIXELS + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE_LINES);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [RW-1:0] REP_LAST     = RW'(PIX_REPEAT - 1);
    localparam logic [AW:0]   FIFO_FULL    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]    CH_MASK      = ~(8'hFF >> COLOUR_SIGNIFICANT_BITS);
    localparam logic [23:0]   RGB_MASK     = {CH_MASK, CH_MASK, CH_MASK};
    localparam logic [23:0]   BORDER_OUT   = BORDER_RGB & RGB_MASK;

    typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;

    state_t          state;
    logic [HW-1:0]   h;
    logic [VW-1:0]   v;
    logic [RW-1:0]   rep;
    logic [23:0]     hold;
    logic [23:0]     rgb;

    logic [24:0]     mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [24:0]     head;

    logic            frame_edge;
    logic            active;
    logic            rep_zero;
    logic            run_now;
    logic            take_ok;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == FIFO_FULL);
    assign empty      = (count == '0);
    assign pix_ready  = en && !full;
    assign push       = pix_valid && pix_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = count;

    always_ff @(posedge clk_pix) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {pix_sof, pix_data};
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign frame_edge = (h == '0) && (v == '0);
    assign active     = (h < H_ACT) && (v < V_ACT);
    assign rep_zero   = (rep == '0);

    // The (0,0) cycle re-decides the mode for the whole frame; IDLE with en=1 lands here
    // with an empty FIFO, so the first frame after enable always runs as border.
    always_comb begin
        run_now = frame_edge ? (!empty && head[24]) : (state == RUN);
        take_ok = !empty && (!head[24] || frame_edge);
        pop     = 1'b0;
        if (en) begin
            if (run_now) pop = active && rep_zero && take_ok;
            else         pop = !empty && !head[24];
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n_pix) begin
        if (!rst_n_pix) begin
            state        <= IDLE;
            h            <= '0;
            v            <= '0;
            rep          <= '0;
            hold         <= '0;
            rgb          <= '0;
            den          <= 1'b0;
            hsync        <= ~H_SYNC_POLARITY;
            vsync        <= ~V_SYNC_POLARITY;
            frame_start  <= 1'b0;
            err_underrun <= 1'b0;
            err_sof      <= 1'b0;
        end else if (!en) begin
            state        <= IDLE;
            h            <= '0;
            v            <= '0;
            rep          <= '0;
            rgb          <= '0;
            den          <= 1'b0;
            hsync        <= ~H_SYNC_POLARITY;
            vsync        <= ~V_SYNC_POLARITY;
            frame_start  <= 1'b0;
            err_underrun <= 1'b0;
            err_sof      <= 1'b0;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end

            if (h < H_ACT) rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
            else           rep <= '0;

            den         <= active;
            hsync       <= (h >= H_SYNC_START && h < H_SYNC_END) ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
            vsync       <= (v >= V_SYNC_START && v < V_SYNC_END) ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
            frame_start <= frame_edge;

            if (run_now) begin
                state <= RUN;
                rgb   <= '0;
                if (active && rep_zero) begin
                    if (take_ok) begin
                        hold <= head[23:0];
                        rgb  <= head[23:0] & RGB_MASK;
                    end else begin
                        // Empty head is an underrun; a non-first sof head is kept for the next frame.
                        state <= SEEK;
                        rgb   <= BORDER_OUT;
                        if (empty) err_underrun <= 1'b1;
                        else       err_sof      <= 1'b1;
                    end
                end else if (active) begin
                    rgb <= hold & RGB_MASK;
                end
            end else begin
                state <= SEEK;
                rgb   <= active ? BORDER_OUT : '0;
            end
        end
    end

    assign {r, g, b} = rgb;

endmodule

// File: tb/tb_smoldvi_stream_frontend.sv
`timescale 1ns/1ps
// Self-checking bench for smoldvi_stream_frontend: random pixel streams against a
// frame/queue-level reference model of timing, resync and error rules.
module tb_smoldvi_stream_frontend;
    localparam int unsigned HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int unsigned VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int unsigned HT = HA + HFP + HSW + HBP;
    localparam int unsigned VT = VA + VFP + VSW + VBP;
    localparam int unsigned FT = HT * VT;
    localparam int unsigned REP = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CSB = 6;
    localparam logic [23:0] BORDER = 24'h102030;

    logic        clk_pix = 1'b0;
    logic        rst_n_pix;
    logic        en;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic        den, hsync, vsync;
    logic [7:0]  r, g, b;
    logic        frame_start, err_underrun, err_sof;
    logic [2:0]  fifo_level;

    smoldvi_stream_frontend #(
        .H_SYNC_POLARITY(1'b0), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW),
        .H_BACK_PORCH(HBP), .H_ACTIVE_PIXELS(HA),
        .V_SYNC_POLARITY(1'b0), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW),
        .V_BACK_PORCH(VBP), .V_ACTIVE_LINES(VA),
        .PIX_REPEAT(REP), .FIFO_DEPTH(DEPTH),
        .COLOUR_SIGNIFICANT_BITS(CSB), .BORDER_RGB(BORDER)
    ) dut (
        .clk_pix(clk_pix), .rst_n_pix(rst_n_pix), .en(en),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .den(den), .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
        .frame_start(frame_start), .err_underrun(err_underrun), .err_sof(err_sof),
        .fifo_level(fifo_level)
    );

    always #5 clk_pix = ~clk_pix;

    int          errors = 0;
    int          checks = 0;
    int unsigned valid_pct = 100;

    logic [24:0] src[$];
    logic [24:0] mq[$];
    int unsigned mt;
    bit          m_run, m_und, m_sof;
    logic [24:0] m_hold;
    logic [33:0] exp_vec;

    function automatic logic [23:0] mask(input logic [23:0] c);
        logic [7:0] m;
        m = ~(8'hFF >> CSB);
        return c & {m, m, m};
    endfunction

    function automatic logic [33:0] dut_vec();
        return {den, hsync, vsync, r, g, b, frame_start, err_underrun, err_sof, pix_ready, fifo_level};
    endfunction

    task automatic model_reset();
        mq.delete();
        mt = 0;
        m_run = 0;
        m_und = 0;
        m_sof = 0;
        m_hold = '0;
    endtask

    // One pixel-clock cycle of the reference: t counts cycles since enable, so the
    // raster position and frame boundaries follow from plain division.
    task automatic model_step(output bit pushed);
        int unsigned hp, ln;
        bit act, rdy, first, hs, vs;
        logic [23:0] col;
        rdy = en && (mq.size() < DEPTH);
        pushed = pix_valid && rdy;
        if (!en) begin
            model_reset();
            exp_vec = {1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
            return;
        end
        hp = mt % HT;
        ln = (mt / HT) % VT;
        act = (hp < HA) && (ln < VA);
        first = (mt % FT) == 0;
        hs = !(hp >= HA + HFP && hp < HA + HFP + HSW);
        vs = !(ln >= VA + VFP && ln < VA + VFP + VSW);
        col = 24'h0;
        if (first) m_run = (mq.size() > 0) && mq[0][24];
        if (m_run) begin
            if (act && (hp % REP) == 0) begin
                if (mq.size() == 0) begin
                    m_und = 1; m_run = 0; col = BORDER;
                end else if (mq[0][24] && !first) begin
                    m_sof = 1; m_run = 0; col = BORDER;
                end else begin
                    m_hold = mq.pop_front();
                    col = m_hold[23:0];
                end
            end else if (act) begin
                col = m_hold[23:0];
            end
        end else begin
            if (mq.size() > 0 && !mq[0][24]) void'(mq.pop_front());
            if (act) col = BORDER;
        end
        if (pushed) mq.push_back({pix_sof, pix_data});
        exp_vec = {act, hs, vs, mask(col), first, m_und, m_sof, mq.size() < DEPTH, 3'(mq.size())};
        mt++;
    endtask

    task automatic tick();
        bit pushed;
        if (src.size() > 0 && $urandom_range(99) < valid_pct) begin
            pix_valid = 1'b1;
            {pix_sof, pix_data} = src[0];
        end else begin
            pix_valid = 1'b0;
            pix_sof = 1'b0;
            pix_data = 24'($urandom);
        end
        model_step(pushed);
        @(posedge clk_pix);
        #1;
        if (pushed) void'(src.pop_front());
    endtask

    task automatic add_frame(input int unsigned n, output logic [23:0] first_px);
        first_px = 24'($urandom);
        src.push_back({1'b1, first_px});
        for (int unsigned i = 1; i < n; i++) src.push_back({1'b0, 24'($urandom)});
    endtask

    task automatic restart();
        en = 1'b0;
        src.delete();
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_pix = 1'b0; en = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        model_reset();
        repeat (2) @(posedge clk_pix);
        #1;
        checks++; if (den !== 1'b0) begin errors++; $display("FAIL reset_den got=%b exp=0", den); end
        checks++; if ({hsync, vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync got=%b exp=11", {hsync, vsync}); end
        checks++; if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=000000", {r, g, b}); end
        checks++; if ({frame_start, err_underrun, err_sof} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {frame_start, err_underrun, err_sof}); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", pix_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        rst_n_pix = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL reset_idle t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
        end
    endtask

    task automatic test_border();
        int den_cnt = 0, fs_cnt = 0;
        restart();
        for (int i = 0; i < 2 * FT; i++) begin
            tick();
            den_cnt += int'(den);
            fs_cnt += int'(frame_start);
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL border t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
        end
        checks++; if (den_cnt !== 64) begin errors++; $display("FAIL border_den_count got=%0d exp=64", den_cnt); end
        checks++; if (fs_cnt !== 2) begin errors++; $display("FAIL border_frame_start got=%0d exp=2", fs_cnt); end
        checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL border_underrun got=%b exp=0", err_underrun); end
    endtask

    task automatic test_stream();
        logic [23:0] f0;
        int fs_cnt = 0;
        restart();
        for (int i = 0; i < 7; i++) add_frame(16, f0);
        for (int i = 0; i < 6 * FT; i++) begin
            tick();
            fs_cnt += int'(frame_start);
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL stream t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
        end
        checks++; if (fs_cnt !== 6) begin errors++; $display("FAIL stream_frame_start got=%0d exp=6", fs_cnt); end
        checks++; if ({err_underrun, err_sof} !== 2'b00) begin errors++; $display("FAIL stream_flags got=%b exp=00", {err_underrun, err_sof}); end
    endtask

    task automatic test_underrun();
        logic [23:0] fa, fb, fc;
        restart();
        add_frame(16, fa);
        add_frame(5, fb);
        for (int i = 0; i < 5 * FT; i++) begin
            if (mt == 230) add_frame(16, fc);
            tick();
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL underrun t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
            if (mt == 2 * FT + HT + 3) begin
                checks++; if ({r, g, b} !== mask(BORDER)) begin errors++; $display("FAIL underrun_slot6 got=%h exp=%h", {r, g, b}, mask(BORDER)); end
                checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag got=%b exp=1", err_underrun); end
            end
            if (mt == 3 * FT + 1) begin
                checks++; if ({den, r, g, b} !== {1'b1, mask(fc)}) begin errors++; $display("FAIL underrun_resume got=%h exp=%h", {den, r, g, b}, {1'b1, mask(fc)}); end
            end
        end
        checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got=%b exp=1", err_underrun); end
    endtask

    task automatic test_sof();
        logic [23:0] fa, fb, fc;
        restart();
        add_frame(16, fa);
        add_frame(10, fb);
        add_frame(16, fc);
        for (int i = 0; i < 5 * FT; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL sof t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
            if (mt == 2 * FT + 2 * HT + 5) begin
                checks++; if ({r, g, b, err_sof} !== {mask(BORDER), 1'b1}) begin errors++; $display("FAIL sof_slot11 got=%h exp=%h", {r, g, b, err_sof}, {mask(BORDER), 1'b1}); end
            end
            if (mt == 3 * FT + 1) begin
                checks++; if ({frame_start, r, g, b} !== {1'b1, mask(fc)}) begin errors++; $display("FAIL sof_next_frame got=%h exp=%h", {frame_start, r, g, b}, {1'b1, mask(fc)}); end
            end
        end
        checks++; if ({err_sof, err_underrun} !== 2'b10) begin errors++; $display("FAIL sof_flags got=%b exp=10", {err_sof, err_underrun}); end
    endtask

    task automatic test_en_drop();
        logic [23:0] f0;
        bit found = 0;
        for (int i = 0; i < 3; i++) add_frame(16, f0);
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL en_drop_run t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
            found = (mq.size() == DEPTH) && (mt % HT) >= 2 && (mt % HT) < HA - 1 && ((mt / HT) % VT) < VA;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL en_drop_setup got=notfull exp=full_midline"); end
        en = 1'b0;
        tick();
        checks++; if ({den, hsync, vsync} !== 3'b011) begin errors++; $display("FAIL en_drop_video got=%b exp=011", {den, hsync, vsync}); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL en_drop_level got=%0d exp=0", fifo_level); end
        checks++; if ({err_sof, err_underrun} !== 2'b00) begin errors++; $display("FAIL en_drop_flags got=%b exp=00", {err_sof, err_underrun}); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL en_drop_ready got=%b exp=0", pix_ready); end
        checks++; if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL en_drop_rgb got=%h exp=000000", {r, g, b}); end
    endtask

    task automatic test_async_reset();
        logic [23:0] f0;
        restart();
        for (int i = 0; i < 3; i++) add_frame(16, f0);
        while (mt != FT + 3 * HT + 3) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL areset_run t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
        end
        #1 rst_n_pix = 1'b0;
        #1;
        checks++; if ({den, hsync, vsync, frame_start} !== 4'b0110) begin errors++; $display("FAIL areset_video got=%b exp=0110", {den, hsync, vsync, frame_start}); end
        checks++; if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL areset_rgb got=%h exp=000000", {r, g, b}); end
        checks++; if ({fifo_level, err_underrun, err_sof} !== 5'd0) begin errors++; $display("FAIL areset_state got=%b exp=00000", {fifo_level, err_underrun, err_sof}); end
        #1 rst_n_pix = 1'b1;
        model_reset();
        src.delete();
        for (int i = 0; i < 2; i++) add_frame(16, f0);
        for (int i = 0; i < 2 * FT; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL areset_after t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
        end
    endtask

    task automatic test_random();
        logic [23:0] f0;
        restart();
        valid_pct = 75;
        for (int i = 0; i < 8; i++) add_frame($urandom_range(20, 12), f0);
        for (int i = 0; i < 6 * FT; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec) begin errors++; $display("FAIL random t=%0d got=%h exp=%h", mt, dut_vec(), exp_vec); end
        end
        valid_pct = 100;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_border();
        test_stream();
        test_underrun();
        test_sof();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
